// File: rtl/key_conditioner.sv
// Per-lane key conditioning: two-flop synchroniser, debounce FSM, registered
// level/press/release outputs and a saturating hold-time counter for four lanes.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_TICK       = 100000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_raw,
  output logic [3:0]  key_level,
  output logic [3:0]  key_press,
  output logic [3:0]  key_release,
  output logic [15:0] hold0,
  output logic [15:0] hold1,
  output logic [15:0] hold2,
  output logic [15:0] hold3,
  output logic        any_press
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = (HOLD_TICK > 1) ? $clog2(HOLD_TICK) : 1;

  localparam logic [DW-1:0] DLAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DONE     = DW'(1);
  localparam logic [PW-1:0] PLAST    = PW'(HOLD_TICK - 1);
  localparam logic [PW-1:0] PONE     = PW'(1);
  localparam logic [3:0]    INACTIVE = ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    DOWN,
    RELEASE_WAIT
  } state_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    s;

  state_e        state_q [4];
  state_e        state_d [4];
  logic [DW-1:0] dcnt_q  [4];
  logic [DW-1:0] dcnt_d  [4];
  logic [PW-1:0] pcnt_q  [4];
  logic [PW-1:0] pcnt_d  [4];
  logic [15:0]   hold_q  [4];
  logic [15:0]   hold_d  [4];

  logic [3:0]    level_q, level_d;
  logic [3:0]    press_q, press_d;
  logic [3:0]    release_q, release_d;
  logic          any_press_q;

  // Polarity is folded after the second flop so the FSM always sees 1 = pressed.
  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      pcnt_d[i]  = pcnt_q[i];
      hold_d[i]  = hold_q[i];

      unique case (state_q[i])
        IDLE: begin
          if (s[i]) begin
            state_d[i] = PRESS_WAIT;
            dcnt_d[i]  = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d[i] = IDLE;
          end else if (dcnt_q[i] == DLAST) begin
            state_d[i] = DOWN;
            press_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DONE;
          end
        end
        DOWN: begin
          if (!s[i]) begin
            state_d[i] = RELEASE_WAIT;
            dcnt_d[i]  = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s[i]) begin
            state_d[i] = DOWN;
          end else if (dcnt_q[i] == DLAST) begin
            state_d[i]   = IDLE;
            release_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DONE;
          end
        end
        default: state_d[i] = IDLE;
      endcase

      // A release glitch (RELEASE_WAIT -> DOWN) keeps counting without a restart.
      if (press_d[i] || release_d[i]) begin
        hold_d[i] = '0;
        pcnt_d[i] = '0;
      end else if (state_q[i] == DOWN || state_q[i] == RELEASE_WAIT) begin
        if (pcnt_q[i] == PLAST) begin
          pcnt_d[i] = '0;
          if (hold_q[i] != 16'hFFFF) begin
            hold_d[i] = hold_q[i] + 16'd1;
          end
        end else begin
          pcnt_d[i] = pcnt_q[i] + PONE;
        end
      end else begin
        hold_d[i] = '0;
        pcnt_d[i] = '0;
      end

      level_d[i] = (state_d[i] == DOWN) || (state_d[i] == RELEASE_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= INACTIVE;
      sync2_q     <= INACTIVE;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
        pcnt_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= |press_d;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        pcnt_q[i]  <= pcnt_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign any_press   = any_press_q;
  assign hold0       = hold_q[0];
  assign hold1       = hold_q[1];
  assign hold2       = hold_q[2];
  assign hold3       = hold_q[3];

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: two instances (active-low D=4/T=3 and
// active-high D=1/T=1) checked against a run-length reference model.
module tb_key_conditioner;

  localparam int unsigned DA = 4;
  localparam int unsigned HA = 3;
  localparam int unsigned DB = 1;
  localparam int unsigned HB = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  raw_a = 4'hF;
  logic [3:0]  raw_b = 4'h0;

  logic [3:0]  lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
  logic [15:0] h0a, h1a, h2a, h3a, h0b, h1b, h2b, h3b;
  logic        any_a, any_b;

  key_conditioner #(.DEBOUNCE_CYCLES(DA), .HOLD_TICK(HA), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .key_raw(raw_a),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
    .hold0(h0a), .hold1(h1a), .hold2(h2a), .hold3(h3a), .any_press(any_a)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DB), .HOLD_TICK(HB), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .key_raw(raw_b),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
    .hold0(h0b), .hold1(h1b), .hold2(h2b), .hold3(h3b), .any_press(any_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  pa, ra, pb, rb;
  } ev_t;

  typedef struct {
    logic [3:0]       la, lb;
    logic [3:0][15:0] ha, hb;
    logic             anya, anyb;
  } st_t;

  ev_t ev_q [$];
  st_t st_q [$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned scyc     = 0;
  bit          done     = 1'b0;

  // Reference model: a lane flips once D+1 consecutive synchronised samples
  // disagree with its level; hold = cycles since press / tick, saturated.
  int unsigned P_D  [2] = '{DA, DB};
  int unsigned P_H  [2] = '{HA, HB};
  bit          P_AL [2] = '{1'b1, 1'b0};
  logic [3:0]  m_sy1 [2];
  logic [3:0]  m_sy2 [2];
  bit          m_lvl [2][4];
  int unsigned m_run [2][4];
  int unsigned m_c   [2][4];

  task automatic chk(input string name, input int unsigned cyc,
                     input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sy1[d] = P_AL[d] ? 4'hF : 4'h0;
      m_sy2[d] = m_sy1[d];
      for (int l = 0; l < 4; l++) begin
        m_lvl[d][l] = 1'b0;
        m_run[d][l] = 0;
        m_c[d][l]   = 0;
      end
    end
  endtask

  task automatic model_edge(input int d, input logic [3:0] r,
                            output logic [3:0] prs, output logic [3:0] rel);
    logic [3:0] s;
    s = P_AL[d] ? ~m_sy2[d] : m_sy2[d];
    m_sy2[d] = m_sy1[d];
    m_sy1[d] = r;
    prs = '0;
    rel = '0;
    for (int l = 0; l < 4; l++) begin
      if (s[l] != m_lvl[d][l]) m_run[d][l]++;
      else m_run[d][l] = 0;
      if (m_run[d][l] == P_D[d] + 1) begin
        m_lvl[d][l] = !m_lvl[d][l];
        m_run[d][l] = 0;
        m_c[d][l]   = 0;
        if (m_lvl[d][l]) prs[l] = 1'b1;
        else rel[l] = 1'b1;
      end else if (m_lvl[d][l]) begin
        m_c[d][l]++;
      end
    end
  endtask

  function automatic logic [15:0] mhold(input int d, input int l);
    int unsigned t;
    if (!m_lvl[d][l]) return 16'h0000;
    t = m_c[d][l] / P_H[d];
    return (t >= 65535) ? 16'hFFFF : t[15:0];
  endfunction

  // Drives one cycle of inputs just after a negedge and logs the expectation
  // for the following posedge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic r);
    ev_t        e;
    st_t        st;
    logic [3:0] pa_, ra_, pb_, rb_;
    bit         assert_now;
    assert_now = (rst == 1'b1) && (r == 1'b0);
    raw_a = a;
    raw_b = b;
    rst   = r;
    if (assert_now) begin
      #1;
      chk("async_clear_flags", scyc, {lvl_a, prs_a, rel_a, any_a, lvl_b, prs_b, rel_b, any_b}, '0);
      chk("async_clear_hold_a", scyc, {h3a, h2a, h1a, h0a}, '0);
      chk("async_clear_hold_b", scyc, {h3b, h2b, h1b, h0b}, '0);
    end
    @(posedge clk);
    scyc++;
    if (!r) begin
      model_reset();
      pa_ = '0; ra_ = '0; pb_ = '0; rb_ = '0;
    end else begin
      model_edge(0, a, pa_, ra_);
      model_edge(1, b, pb_, rb_);
    end
    for (int l = 0; l < 4; l++) begin
      st.la[l] = m_lvl[0][l];
      st.lb[l] = m_lvl[1][l];
      st.ha[l] = mhold(0, l);
      st.hb[l] = mhold(1, l);
    end
    st.anya = |pa_;
    st.anyb = |pb_;
    st_q.push_back(st);
    if (|{pa_, ra_, pb_, rb_}) begin
      e.cyc = scyc;
      e.pa = pa_; e.ra = ra_; e.pb = pb_; e.rb = rb_;
      ev_q.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares levels/holds every cycle and pops an expected event
  // whenever either DUT presents a strobe.
  initial begin
    int unsigned n;
    st_t         st;
    ev_t         e;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (st_q.size() != 0) begin
        st = st_q.pop_front();
        chk("level_a", n, lvl_a, st.la);
        chk("level_b", n, lvl_b, st.lb);
        chk("hold_a", n, {h3a, h2a, h1a, h0a}, st.ha);
        chk("hold_b", n, {h3b, h2b, h1b, h0b}, st.hb);
        chk("any_press_a", n, any_a, st.anya);
        chk("any_press_b", n, any_b, st.anyb);
      end
      while (ev_q.size() != 0 && ev_q[0].cyc < n) begin
        e = ev_q.pop_front();
        chk("missed_strobe", e.cyc, 16'h0000, {e.pa, e.ra, e.pb, e.rb});
      end
      if (|{prs_a, rel_a, prs_b, rel_b}) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_strobe", n, {prs_a, rel_a, prs_b, rel_b}, 16'h0000);
        end else begin
          e = ev_q.pop_front();
          chk("strobe_cycle", n, n, e.cyc);
          chk("strobe_mask", n, {prs_a, rel_a, prs_b, rel_b}, {e.pa, e.ra, e.pb, e.rb});
        end
      end
    end
  end

  initial begin
    logic [3:0] a, b;
    model_reset();
    repeat (3) step(4'hF, 4'h0, 1'b0);
    repeat (3) step(4'hF, 4'h0, 1'b1);
    // clean press on lane 0, then bounce on lane 1 while lane 0 is held
    repeat (15) step(4'hE, 4'h0, 1'b1);
    repeat (3)  step(4'hC, 4'h0, 1'b1);
    repeat (10) step(4'hE, 4'h0, 1'b1);
    // release glitch, then clean release
    repeat (2)  step(4'hF, 4'h0, 1'b1);
    repeat (10) step(4'hE, 4'h0, 1'b1);
    repeat (12) step(4'hF, 4'h0, 1'b1);
    // all lanes together, reset while held, re-acceptance, release
    repeat (12) step(4'h0, 4'h0, 1'b1);
    repeat (3)  step(4'h0, 4'h0, 1'b0);
    repeat (15) step(4'h0, 4'h0, 1'b1);
    repeat (12) step(4'hF, 4'h0, 1'b1);
    // single-cycle debounce: one-sample bounce, then press and release
    step(4'hF, 4'h1, 1'b1);
    repeat (4) step(4'hF, 4'h0, 1'b1);
    repeat (4) step(4'hF, 4'h1, 1'b1);
    repeat (4) step(4'hF, 4'h0, 1'b1);
    // random toggling with occasional resets
    a = 4'hF;
    b = 4'h0;
    repeat (3000) begin
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(7) == 0) a[l] = ~a[l];
        if ($urandom_range(3) == 0) b[l] = ~b[l];
      end
      step(a, b, ($urandom_range(499) == 0) ? 1'b0 : 1'b1);
    end
    repeat (12) step(4'hF, 4'h0, 1'b1);
    // hold counter saturation on lane 2 of the single-tick instance
    repeat (70000) step(4'hF, 4'h4, 1'b1);
    chk("hold2_saturated", scyc, h2b, 16'hFFFF);
    repeat (10) step(4'hF, 4'h4, 1'b1);
    chk("hold2_no_wrap", scyc, h2b, 16'hFFFF);
    repeat (4) step(4'hF, 4'h0, 1'b1);
    done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("events_drained", scyc, ev_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
